edge_detect_bank: RTL and testbench

Multi-channel, parametrised edge detector for asynchronous control and status lines entering the signal-processing clock domain (chirp triggers, frame syncs, ADC-ready strobes). Each channel has its own synchroniser, programmable glitch filter, per-channel edge-mode select (rising/falling/both/off), single-cycle edge pulse, sticky pending flag with overrun detection, and a shared interrupt output. It is the drop-in replacement for single-channel, fixed-mode, unfiltered edge capture.

---
 rtl/edge_detect_bank.sv | 50 +++++
 tb/tb_edge_detect_bank.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_bank.sv
// edge_detect_bank: per-channel synchronised, glitch-filtered edge detector with sticky flags and shared irq
module edge_detect_bank #(
  parameter int CH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH-1:0]     signal_i,
  input  logic [2*CH-1:0]   edge_mode_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic [CH-1:0]     clr_i,
  output logic [CH-1:0]     level_o,
  output logic [CH-1:0]     edge_pulse_o,
  output logic [CH-1:0]     pending_o,
  output logic [CH-1:0]     overrun_o,
  output logic              irq_o
);
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [FILT_W-1:0]      cnt;
    logic                   lvl, pls, pnd, ovr, s, upd, qual;
    assign s    = sync[SYNC_STAGES-1];
    assign upd  = (s != lvl) && (cnt >= filt_len_i);
    assign qual = upd && (s ? edge_mode_i[2*c] : edge_mode_i[2*c+1]);
    // synchronise, filter, then register the edge pulse and sticky flags (a new event beats a clear)
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync <= '0;
        cnt  <= '0;
        lvl  <= 1'b0;
        pls  <= 1'b0;
        pnd  <= 1'b0;
        ovr  <= 1'b0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], signal_i[c]};
        cnt  <= (s == lvl || upd) ? '0 : cnt + 1'b1;
        lvl  <= upd ? s : lvl;
        pls  <= qual;
        pnd  <= qual | (pnd & ~clr_i[c]);
        ovr  <= ((qual & pnd) | ovr) & ~clr_i[c];
      end
    end
    assign level_o[c]      = lvl;
    assign edge_pulse_o[c] = pls;
    assign pending_o[c]    = pnd;
    assign overrun_o[c]    = ovr;
  end
  assign irq_o = |pending_o;
endmodule

// File: tb/tb_edge_detect_bank.sv
// tb_edge_detect_bank: random and directed stimulus checked against a run-length behavioural model
module tb_edge_detect_bank;
  localparam int CH = 4;
  localparam int SS = 2;
  localparam int FW = 4;
  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   signal_i = '0;
  logic [2*CH-1:0] edge_mode_i = '0;
  logic [FW-1:0]   filt_len_i = '0;
  logic [CH-1:0]   clr_i = '0;
  logic [CH-1:0]   level_o, edge_pulse_o, pending_o, overrun_o;
  logic            irq_o;
  logic [CH-1:0]   m_lvl, m_pls, m_pnd, m_ovr;
  int              streak [CH];
  logic [CH-1:0]   hist [$];
  int              n_vec = 0;
  int              n_mis = 0;

  edge_detect_bank #(.CH(CH), .SYNC_STAGES(SS), .FILT_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .signal_i(signal_i), .edge_mode_i(edge_mode_i),
    .filt_len_i(filt_len_i), .clr_i(clr_i), .level_o(level_o), .edge_pulse_o(edge_pulse_o),
    .pending_o(pending_o), .overrun_o(overrun_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_lvl = '0; m_pls = '0; m_pnd = '0; m_ovr = '0;
    for (int c = 0; c < CH; c++) streak[c] = 0;
    hist.delete();
  endtask

  // The synchronised view of an input is simply what was sampled SS edges ago; a level
  // change is accepted once it has been seen for more than filt_len consecutive edges.
  task automatic model_step();
    logic [CH-1:0] s;
    logic q;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s = (hist.size() >= SS) ? hist[0] : '0;
    hist.push_back(signal_i);
    if (hist.size() > SS) void'(hist.pop_front());
    for (int c = 0; c < CH; c++) begin
      q = 1'b0;
      if (s[c] == m_lvl[c]) streak[c] = 0;
      else begin
        streak[c]++;
        if (streak[c] > int'(filt_len_i)) begin
          m_lvl[c] = s[c];
          streak[c] = 0;
          q = s[c] ? edge_mode_i[2*c] : edge_mode_i[2*c+1];
        end
      end
      m_ovr[c] = ((q && m_pnd[c]) || m_ovr[c]) && !clr_i[c];
      m_pnd[c] = q || (m_pnd[c] && !clr_i[c]);
      m_pls[c] = q;
    end
  endtask

  task automatic cmp();
    n_vec++;
    if (level_o !== m_lvl) begin n_mis++; $display("FAIL level_o got %b exp %b at %0t", level_o, m_lvl, $time); end
    if (edge_pulse_o !== m_pls) begin n_mis++; $display("FAIL edge_pulse_o got %b exp %b at %0t", edge_pulse_o, m_pls, $time); end
    if (pending_o !== m_pnd) begin n_mis++; $display("FAIL pending_o got %b exp %b at %0t", pending_o, m_pnd, $time); end
    if (overrun_o !== m_ovr) begin n_mis++; $display("FAIL overrun_o got %b exp %b at %0t", overrun_o, m_ovr, $time); end
    if (irq_o !== (|m_pnd)) begin n_mis++; $display("FAIL irq_o got %b exp %b at %0t", irq_o, |m_pnd, $time); end
  endtask

  task automatic lit(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got %b exp %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp();
  endtask

  task automatic lit_all_zero(input string name);
    for (int c = 0; c < CH; c++) begin
      lit({name, "_level"}, level_o[c], 1'b0);
      lit({name, "_pulse"}, edge_pulse_o[c], 1'b0);
      lit({name, "_pending"}, pending_o[c], 1'b0);
      lit({name, "_overrun"}, overrun_o[c], 1'b0);
    end
    lit({name, "_irq"}, irq_o, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1 lit_all_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    edge_mode_i = 8'b00_00_00_01;
    signal_i[0] = 1'b1;
    tick(); tick(); tick();
    lit("lat_pulse0", edge_pulse_o[0], 1'b1);
    lit("lat_pending0", pending_o[0], 1'b1);
    lit("lat_level0", level_o[0], 1'b1);
    lit("lat_irq", irq_o, 1'b1);
    tick();
    lit("lat_pulse0_end", edge_pulse_o[0], 1'b0);
    edge_mode_i = 8'b11_00_00_01;
    signal_i[3] = 1'b1;
    tick(); tick();
    clr_i[3] = 1'b1;
    tick();
    clr_i[3] = 1'b0;
    lit("setwins_pulse3", edge_pulse_o[3], 1'b1);
    lit("setwins_pending3", pending_o[3], 1'b1);
    lit("setwins_overrun3", overrun_o[3], 1'b0);
    edge_mode_i[5:4] = 2'b01;
    signal_i[2] = 1'b1;
    tick(); tick(); tick();
    lit("ovr_first_pending2", pending_o[2], 1'b1);
    lit("ovr_first_overrun2", overrun_o[2], 1'b0);
    signal_i[2] = 1'b0;
    tick(); tick(); tick();
    signal_i[2] = 1'b1;
    tick(); tick(); tick();
    lit("ovr_second_pulse2", edge_pulse_o[2], 1'b1);
    lit("ovr_pending2", pending_o[2], 1'b1);
    lit("ovr_overrun2", overrun_o[2], 1'b1);
    clr_i = 4'b0100;
    tick();
    clr_i = '0;
    lit("clr_pending2", pending_o[2], 1'b0);
    lit("clr_overrun2", overrun_o[2], 1'b0);
    clr_i = 4'b1111;
    tick();
    clr_i = '0;
    lit("clr_all_irq", irq_o, 1'b0);
    filt_len_i = 4'd3;
    edge_mode_i[3:2] = 2'b01;
    signal_i[1] = 1'b1;
    tick(); tick(); tick();
    signal_i[1] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    lit("glitch3_level1", level_o[1], 1'b0);
    lit("glitch3_pending1", pending_o[1], 1'b0);
    signal_i[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 3) signal_i[1] = 1'b0;
      lit("glitch4_pulse1", edge_pulse_o[1], i == 5);
    end
    filt_len_i = 4'd0;
    edge_mode_i = 8'b11_10_01_00;
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 0) signal_i = ~signal_i;
      tick();
    end
    lit("mode_off_pending0", pending_o[0], 1'b0);
    signal_i = '0;
    for (int i = 0; i < 4; i++) tick();
    edge_mode_i = 8'h55;
    filt_len_i = 4'd7;
    signal_i = '1;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    model_reset();
    #1 lit_all_zero("midreset");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      lit("postreset_pulse0", edge_pulse_o[0], i == 9);
    end
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0) signal_i[c] = ~signal_i[c];
        clr_i[c] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 49) == 0) edge_mode_i = 8'($urandom);
      if ($urandom_range(0, 99) == 0) filt_len_i = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
